// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse arming scheduler.
//   ch_state_t   : per-channel arming state
//   scan_state_t : packet scanner state
//   ts_t         : packed timestamp {year16, month8, day8, hour8, minutes8, seconds8}
//   TS_W         : width of a packed timestamp
package pulse_sched_pkg;

  localparam int TS_W = 56;

  typedef enum logic [2:0] {
    CH_IDLE  = 3'd0,
    CH_WAIT  = 3'd1,
    CH_ARMED = 3'd2,
    CH_RUN   = 3'd3,
    CH_LATE  = 3'd4
  } ch_state_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } ts_t;

  // The field order makes the packed value monotonic in time, so a plain
  // unsigned compare orders two timestamps.
  function automatic logic ts_before(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/pps_edge_watchdog.sv
// PPS conditioning: two-flop synchronizer, rising-edge detect and a loss
// watchdog.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   pps_raw  : raw PPS, asynchronous to clk
//   pps_edge : registered one-cycle pulse, two edges after pps_raw is first
//              sampled high
//   pps_lost : high while TIMEOUT_CYC cycles have elapsed without an edge
module pps_edge_watchdog #(
  parameter int TIMEOUT_CYC = 11_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pps_raw,
  output logic pps_edge,
  output logic pps_lost
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      pps_edge <= 1'b0;
      cnt_q    <= '0;
      pps_lost <= 1'b0;
    end else begin
      // stage p0/p1: metastability filter
      sync_p0  <= pps_raw;
      sync_p1  <= sync_p0;
      // stage p2: previous value for edge detect, edge registered here
      sync_p2  <= sync_p1;
      pps_edge <= sync_p1 & ~sync_p2;
      // watchdog restarts on the same edge pulse that drives the fire strobes
      if (pps_edge) begin
        cnt_q    <= '0;
        pps_lost <= 1'b0;
      end else begin
        cnt_q    <= sat_inc(cnt_q);
        pps_lost <= (sat_inc(cnt_q) == CNT_MAX);
      end
    end
  end

endmodule

// File: rtl/pulse_arm_scheduler.sv
// Multi-channel arming scheduler. Each channel holds a start timestamp; every
// Thunderbolt packet is scanned against the waiting channels (one per cycle)
// and matching channels are armed to fire on the PPS edge the packet labels.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_pps_raw             : raw PPS input
//   i_pulse_enable[N_CH]  : per-channel enable; low forces IDLE
//   i_thunder_packet_dv   : packet strobe, i_thunder_ts is the packet time
//   i_cfg_wr/ch/ts/repeat : channel programming, accepted while o_cfg_ready
//   o_cfg_ready           : scanner idle
//   o_fire[N_CH]          : one-cycle start strobe, 3 cycles after PPS rises
//   o_armed[N_CH]         : channel ARMED or RUN
//   o_late[N_CH]          : channel LATE (start time already passed)
//   o_pps_lost            : PPS watchdog timed out
module pulse_arm_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_CH            = 8,
  parameter int PPS_TIMEOUT_CYC = 11_000_000,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pps_raw,
  input  logic [N_CH-1:0]   i_pulse_enable,
  input  logic              i_thunder_packet_dv,
  input  logic [TS_W-1:0]   i_thunder_ts,
  input  logic              i_cfg_wr,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [TS_W-1:0]   i_cfg_ts,
  input  logic              i_cfg_repeat,
  output logic              o_cfg_ready,
  output logic [N_CH-1:0]   o_fire,
  output logic [N_CH-1:0]   o_armed,
  output logic [N_CH-1:0]   o_late,
  output logic              o_pps_lost
);

  logic              pps_edge;
  logic              pps_lost;
  logic              lost_q;
  logic              lost_rise;
  logic              cfg_acc;
  logic              scan_eval;

  scan_state_t       scan_q;
  logic [CH_W-1:0]   idx_q;
  ts_t               pkt_q;

  logic [TS_W-1:0]   ts_q  [N_CH];
  logic              rep_q [N_CH];
  ch_state_t         st_q  [N_CH];
  ch_state_t         st_d  [N_CH];
  logic [N_CH-1:0]   fire_d;
  logic [N_CH-1:0]   armed_d;
  logic [N_CH-1:0]   late_d;

  pps_edge_watchdog #(
    .TIMEOUT_CYC(PPS_TIMEOUT_CYC)
  ) u_wd (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .pps_raw  (i_pps_raw),
    .pps_edge (pps_edge),
    .pps_lost (pps_lost)
  );

  assign o_pps_lost = pps_lost;
  assign lost_rise  = pps_lost & ~lost_q;
  assign cfg_acc    = i_cfg_wr & o_cfg_ready;
  // A restarting packet suppresses evaluation so every channel is judged
  // against the newest time only.
  assign scan_eval  = (scan_q == S_SCAN) && !i_thunder_packet_dv;

  // Configuration and packet time are data: no reset, gated by channel state.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_acc && (i_cfg_ch == CH_W'(i))) begin
        ts_q[i]  <= i_cfg_ts;
        rep_q[i] <= i_cfg_repeat;
      end
    end
    if (i_thunder_packet_dv) begin
      pkt_q <= i_thunder_ts;
    end
  end

  // Scanner: one channel per cycle, a new packet restarts at index 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_q      <= S_IDLE;
      idx_q       <= '0;
      o_cfg_ready <= 1'b1;
    end else if (i_thunder_packet_dv) begin
      scan_q      <= S_SCAN;
      idx_q       <= '0;
      o_cfg_ready <= 1'b0;
    end else if (scan_q == S_SCAN) begin
      if (idx_q == CH_W'(N_CH - 1)) begin
        scan_q      <= S_IDLE;
        idx_q       <= '0;
        o_cfg_ready <= 1'b1;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Channel next state. Priority: enable, config write, then PPS over
  // watchdog loss for ARMED channels.
  always_comb begin
    fire_d  = '0;
    armed_d = '0;
    late_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      if (!i_pulse_enable[i]) begin
        st_d[i] = CH_IDLE;
      end else if (cfg_acc && (i_cfg_ch == CH_W'(i))) begin
        st_d[i] = CH_WAIT;
      end else begin
        case (st_q[i])
          CH_WAIT: begin
            if (scan_eval && (idx_q == CH_W'(i))) begin
              if (ts_q[i] == pkt_q) begin
                st_d[i] = CH_ARMED;
              end else if (ts_before(ts_q[i], pkt_q)) begin
                st_d[i] = CH_LATE;
              end
            end
          end
          CH_ARMED: begin
            if (pps_edge) begin
              fire_d[i] = 1'b1;
              st_d[i]   = rep_q[i] ? CH_RUN : CH_IDLE;
            end else if (lost_rise) begin
              st_d[i] = CH_LATE;
            end
          end
          CH_RUN: begin
            if (pps_edge) begin
              fire_d[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      armed_d[i] = (st_d[i] == CH_ARMED) || (st_d[i] == CH_RUN);
      late_d[i]  = (st_d[i] == CH_LATE);
    end
  end

  // stage p3: channel state and strobes registered together
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= CH_IDLE;
      end
      o_fire  <= '0;
      o_armed <= '0;
      o_late  <= '0;
      lost_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= st_d[i];
      end
      o_fire  <= fire_d;
      o_armed <= armed_d;
      o_late  <= late_d;
      lost_q  <= pps_lost;
    end
  end

endmodule

// File: tb/tb_pulse_arm_scheduler.sv
// Self-checking bench for pulse_arm_scheduler: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pulse_arm_scheduler;
  import pulse_sched_pkg::*;

  localparam int N   = 8;
  localparam int TMO = 300;
  localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_RUN = 3, M_LATE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pps_raw = 1'b0;
  logic [N-1:0]  en = '1;
  logic          dv = 1'b0;
  logic [55:0]   thunder_ts = '0;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_ch = '0;
  logic [55:0]   cfg_ts = '0;
  logic          cfg_rep = 1'b0;
  logic          ready;
  logic [N-1:0]  fire, armed, late;
  logic          lost;

  always #5 clk = ~clk;

  pulse_arm_scheduler #(.N_CH(N), .PPS_TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pps_raw(pps_raw), .i_pulse_enable(en),
    .i_thunder_packet_dv(dv), .i_thunder_ts(thunder_ts), .i_cfg_wr(cfg_wr),
    .i_cfg_ch(cfg_ch), .i_cfg_ts(cfg_ts), .i_cfg_repeat(cfg_rep),
    .o_cfg_ready(ready), .o_fire(fire), .o_armed(armed), .o_late(late),
    .o_pps_lost(lost)
  );

  int cyc = 0, n_checks = 0, n_fail = 0;
  int fire_cnt [N];
  int last_fire [N];

  // behavioural model state
  int           m_st [N];
  logic [55:0]  m_ts [N];
  bit           m_rep [N];
  logic [N-1:0] m_fire;
  logic [55:0]  m_pkt;
  bit           m_scan, m_ready, m_lost, m_lost_d;
  int           m_idx, m_since;
  bit           r0, r1, r2, r3;  // raw PPS sampled 1..4 edges ago

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [55:0] mk_ts(input int sec);
    ts_t t;
    t.year = 16'd2020; t.month = 8'd7; t.day = 8'd15;
    t.hour = 8'd11; t.minutes = 8'd55; t.seconds = 8'(sec);
    return t;
  endfunction

  function automatic logic [N-1:0] exp_armed();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_st[i] == M_ARMED) || (m_st[i] == M_RUN);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_late();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_st[i] == M_LATE);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = M_IDLE;
    m_fire = '0; m_scan = 0; m_idx = 0; m_ready = 1;
    m_lost = 0; m_lost_d = 0; m_since = 0;
    r0 = 0; r1 = 0; r2 = 0; r3 = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held at it.
  task automatic model_edge();
    bit pps, lrise, acc, ev;
    pps   = r2 && !r3;            // raw first seen high three edges ago
    lrise = m_lost && !m_lost_d;
    acc   = cfg_wr && m_ready;
    ev    = m_scan && !dv;
    m_fire = '0;
    for (int i = 0; i < N; i++) begin
      if (!en[i]) m_st[i] = M_IDLE;
      else if (acc && int'(cfg_ch) == i) m_st[i] = M_WAIT;
      else if (m_st[i] == M_ARMED) begin
        if (pps) begin
          m_fire[i] = 1'b1;
          m_st[i] = m_rep[i] ? M_RUN : M_IDLE;
        end else if (lrise) m_st[i] = M_LATE;
      end else if (m_st[i] == M_RUN) begin
        if (pps) m_fire[i] = 1'b1;
      end else if (m_st[i] == M_WAIT && ev && m_idx == i) begin
        if (m_ts[i] == m_pkt) m_st[i] = M_ARMED;
        else if (m_ts[i] < m_pkt) m_st[i] = M_LATE;
      end
    end
    if (acc) begin
      m_ts[cfg_ch] = cfg_ts;
      m_rep[cfg_ch] = cfg_rep;
    end
    if (dv) begin
      m_pkt = thunder_ts; m_idx = 0; m_scan = 1;
    end else if (m_scan) begin
      m_idx++;
      if (m_idx == N) m_scan = 0;
    end
    m_ready  = !m_scan;
    m_lost_d = m_lost;
    if (pps) m_since = 0;
    else if (m_since < TMO) m_since++;
    m_lost = (m_since >= TMO);
    r3 = r2; r2 = r1; r1 = r0; r0 = pps_raw;
  endtask

  task automatic check_outputs();
    check_eq("fire", 64'(fire), 64'(m_fire));
    check_eq("armed", 64'(armed), 64'(exp_armed()));
    check_eq("late", 64'(late), 64'(exp_late()));
    check_eq("pps_lost", 64'(lost), 64'(m_lost));
    check_eq("cfg_ready", 64'(ready), 64'(m_ready));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        fire_cnt[i]++;
        last_fire[i] = cyc;
      end
    end
    check_outputs();
  endtask

  task automatic write_cfg(input int ch, input logic [55:0] ts, input bit rep);
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("cfg_ready_wait", 64'(ready), 64'd1);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_ts = ts; cfg_rep = rep;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [55:0] ts);
    dv = 1'b1; thunder_ts = ts;
    tick();
    dv = 1'b0;
    repeat (N) tick();
  endtask

  task automatic pps_pulse(output int samp_cyc);
    pps_raw = 1'b1;
    tick();
    samp_cyc = cyc;
    repeat (3) tick();
    pps_raw = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int sc, sc30, f0;
    for (int i = 0; i < N; i++) begin
      fire_cnt[i] = 0; last_fire[i] = 0; m_ts[i] = '0; m_rep[i] = 0;
    end
    model_reset();
    repeat (3) tick();
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_fire", 64'(fire), 64'd0);
    check_eq("rst_lost", 64'(lost), 64'd0);
    rst_n = 1'b1;

    // one-shot ch0 and repeat ch3, both at seconds 30
    write_cfg(0, mk_ts(30), 1'b0);
    write_cfg(3, mk_ts(30), 1'b1);
    sc30 = 0;
    for (int s = 28; s <= 32; s++) begin
      send_pkt(mk_ts(s));
      pps_pulse(sc);
      if (s == 30) sc30 = sc;
    end
    check_eq("oneshot_count", 64'(fire_cnt[0]), 64'd1);
    check_eq("oneshot_latency", 64'(last_fire[0] - sc30), 64'd3);
    check_eq("oneshot_idle", 64'(armed[0]), 64'd0);
    check_eq("repeat_count", 64'(fire_cnt[3]), 64'd3);
    check_eq("repeat_run", 64'(armed[3]), 64'd1);
    en[3] = 1'b0;
    tick();
    send_pkt(mk_ts(33));
    pps_pulse(sc);
    check_eq("disabled_count", 64'(fire_cnt[3]), 64'd3);
    en[3] = 1'b1;

    // late start: ch1 at 25, ch6 at 20, packet 28
    write_cfg(1, mk_ts(25), 1'b0);
    write_cfg(6, mk_ts(20), 1'b0);
    dv = 1'b1; thunder_ts = mk_ts(28);
    tick();
    dv = 1'b0;
    tick();
    check_eq("late1_idx0", 64'(late[1]), 64'd0);
    tick();
    check_eq("late1_idx1", 64'(late[1]), 64'd1);
    repeat (N - 2) tick();
    check_eq("late6", 64'(late[6]), 64'd1);
    pps_pulse(sc);
    check_eq("late1_nofire", 64'(fire_cnt[1]), 64'd0);
    write_cfg(1, mk_ts(50), 1'b0);
    check_eq("late1_cleared", 64'(late[1]), 64'd0);

    // packet restart and write gating
    write_cfg(4, mk_ts(61), 1'b0);
    write_cfg(5, mk_ts(60), 1'b0);
    dv = 1'b1; thunder_ts = mk_ts(60);
    tick();
    dv = 1'b0;
    repeat (3) tick();
    cfg_wr = 1'b1; cfg_ch = 3'd6; cfg_ts = mk_ts(99); cfg_rep = 1'b0;
    tick();
    cfg_wr = 1'b0;
    dv = 1'b1; thunder_ts = mk_ts(61);
    tick();
    dv = 1'b0;
    check_eq("restart_busy", 64'(ready), 64'd0);
    repeat (N) tick();
    check_eq("ignored_wr", 64'(late[6]), 64'd1);
    check_eq("restart_late5", 64'(late[5]), 64'd1);
    check_eq("restart_arm4", 64'(armed[4]), 64'd1);
    pps_pulse(sc);
    check_eq("restart_fire4", 64'(fire_cnt[4]), 64'd1);

    // PPS loss: arm ch2, then starve the watchdog
    write_cfg(2, mk_ts(40), 1'b0);
    send_pkt(mk_ts(40));
    check_eq("loss_armed", 64'(armed[2]), 64'd1);
    repeat (TMO + 5) tick();
    check_eq("loss_flag", 64'(lost), 64'd1);
    check_eq("loss_late2", 64'(late[2]), 64'd1);
    pps_pulse(sc);
    check_eq("loss_cleared", 64'(lost), 64'd0);
    check_eq("loss_nofire", 64'(fire_cnt[2]), 64'd0);

    // reset while ch0 is ARMED and the PPS edge is one cycle from firing
    write_cfg(0, mk_ts(70), 1'b0);
    send_pkt(mk_ts(70));
    check_eq("rst_armed", 64'(armed[0]), 64'd1);
    f0 = fire_cnt[0];
    pps_raw = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_fire", 64'(fire), 64'd0);
    check_eq("rstmid_armed", 64'(armed), 64'd0);
    check_eq("rstmid_late", 64'(late), 64'd0);
    check_eq("rstmid_lost", 64'(lost), 64'd0);
    check_eq("rstmid_ready", 64'(ready), 64'd1);
    model_reset();
    pps_raw = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_eq("rst_nofire", 64'(fire_cnt[0]), 64'(f0));

    // randomized traffic with one long PPS gap
    for (int c = 0; c < 2500; c++) begin
      if (c >= 1200 && c < 1560) pps_raw = 1'b0;
      else if ($urandom_range(0, 24) == 0) pps_raw = ~pps_raw;
      dv         = ($urandom_range(0, 39) == 0);
      thunder_ts = mk_ts($urandom_range(0, 7));
      cfg_wr     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 3'($urandom_range(0, 7));
      cfg_ts     = mk_ts($urandom_range(0, 7));
      cfg_rep    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) en[$urandom_range(0, 7)] ^= 1'b1;
      tick();
    end
    dv = 1'b0; cfg_wr = 1'b0; pps_raw = 1'b0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
